// File: rtl/reg_window_pkg.sv
// Shared types and defaults for the SHA-256 message-schedule register window.
package reg_window_pkg;

    localparam int unsigned SHA_WORD_W    = 32;
    localparam int unsigned SHA_WIN_DEPTH = 16;

    // Decoded per-edge command, highest priority first: clear, load, shift, hold
    typedef enum logic [1:0] {
        CMD_HOLD  = 2'd0,
        CMD_SHIFT = 2'd1,
        CMD_LOAD  = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

endpackage

// File: rtl/reg_window_shift_if.sv
// Command/data bus of the register window; master drives commands, slave is the window.
interface reg_window_shift_if
    import reg_window_pkg::*;
#(
    parameter int unsigned WIDTH = SHA_WORD_W,
    parameter int unsigned DEPTH = SHA_WIN_DEPTH,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) ();

    logic                     clr;
    logic                     load;
    logic                     shift;
    logic [WIDTH-1:0]         data_i;
    logic [DEPTH*WIDTH-1:0]   block_i;
    logic [DEPTH*WIDTH-1:0]   window_o;
    logic [WIDTH-1:0]         oldest_o;
    logic [WIDTH-1:0]         newest_o;
    logic [CW-1:0]            count_o;
    logic                     full_o;

    modport master (
        output clr, load, shift, data_i, block_i,
        input  window_o, oldest_o, newest_o, count_o, full_o
    );

    modport slave (
        input  clr, load, shift, data_i, block_i,
        output window_o, oldest_o, newest_o, count_o, full_o
    );

endinterface

// File: rtl/reg_window_cell.sv
// One word of the window: sync active-low reset, clear, and enabled 2:1 next-value select.
module reg_window_cell #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             sel_blk,
    input  logic [WIDTH-1:0] nbr,
    input  logic [WIDTH-1:0] blk,
    output logic [WIDTH-1:0] q
);

    // Word register; the unselected source is never sampled, so X on it cannot leak in
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= sel_blk ? blk : nbr;
        end
    end

endmodule

// File: rtl/reg_window_shift.sv
// DEPTH x WIDTH register window with block load, slide-in, clear and hold.
// Optional fill counter (count_o/full_o) is built only when REGWIN_COUNT_EN is defined;
// otherwise both are tied to zero.
module reg_window_shift
    import reg_window_pkg::*;
#(
    parameter int unsigned WIDTH = SHA_WORD_W,
    parameter int unsigned DEPTH = SHA_WIN_DEPTH
) (
    input  logic               CLK,
    input  logic               RST,
    reg_window_shift_if.slave  bus
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    cmd_e             cmd;
    logic             word_en;
    logic             word_sel_blk;
    logic             word_clr;
    logic [WIDTH-1:0] words [DEPTH];
    logic [WIDTH-1:0] nbrs  [DEPTH];

    // Priority encoder: clear > load > shift > hold
    always_comb begin
        cmd = CMD_HOLD;
        if (bus.clr) begin
            cmd = CMD_CLEAR;
        end else if (bus.load) begin
            cmd = CMD_LOAD;
        end else if (bus.shift) begin
            cmd = CMD_SHIFT;
        end
    end

    // Per-word control shared by every cell
    always_comb begin
        word_clr     = (cmd == CMD_CLEAR);
        word_sel_blk = (cmd == CMD_LOAD);
        word_en      = (cmd == CMD_LOAD) || (cmd == CMD_SHIFT);
    end

    for (genvar i = 0; i < int'(DEPTH); i++) begin : g_word
        if (i == int'(DEPTH) - 1) begin : g_newest
            assign nbrs[i] = bus.data_i;
        end else begin : g_inner
            assign nbrs[i] = words[i+1];
        end

        reg_window_cell #(.WIDTH(WIDTH)) u_cell (
            .clk     (CLK),
            .rst_n   (RST),
            .clr     (word_clr),
            .en      (word_en),
            .sel_blk (word_sel_blk),
            .nbr     (nbrs[i]),
            .blk     (bus.block_i[i*WIDTH +: WIDTH]),
            .q       (words[i])
        );

        assign bus.window_o[i*WIDTH +: WIDTH] = words[i];
    end

    assign bus.oldest_o = words[0];
    assign bus.newest_o = words[DEPTH-1];

`ifdef REGWIN_COUNT_EN
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_nxt;
    logic          full_q;

    // Saturating fill count: load fills, shift adds one up to DEPTH, clear empties
    always_comb begin
        count_nxt = count_q;
        unique case (cmd)
            CMD_CLEAR: count_nxt = '0;
            CMD_LOAD:  count_nxt = CW'(DEPTH);
            CMD_SHIFT: count_nxt = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
            default:   count_nxt = count_q;
        endcase
    end

    // Count and full flag registered together so they move on the same edge
    always_ff @(posedge CLK) begin
        if (!RST) begin
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign bus.count_o = count_q;
    assign bus.full_o  = full_q;
`else
    assign bus.count_o = '0;
    assign bus.full_o  = 1'b0;
`endif

endmodule

// File: tb/tb_reg_window_shift.sv
// Directed bench for reg_window_shift (WIDTH=32, DEPTH=16); count expectations follow REGWIN_COUNT_EN.
module tb_reg_window_shift;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 16;
    localparam int unsigned BW = 512;

    logic CLK;
    logic RST;
    int   n_asrt;
    int   n_fail;
    logic [D*W-1:0] exp_win;

    reg_window_shift_if #(.WIDTH(W), .DEPTH(D)) bus ();

    reg_window_shift #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        n_asrt++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [BW-1:0] ecnt(input int n);
`ifdef REGWIN_COUNT_EN
        return BW'(n);
`else
        return BW'(n * 0);
`endif
    endfunction

    function automatic logic [BW-1:0] efull(input bit f);
`ifdef REGWIN_COUNT_EN
        return BW'(f);
`else
        return BW'(f & 1'b0);
`endif
    endfunction

    task automatic chk_cnt(input string tag, input int n, input bit f);
        chk({tag, "_count"}, BW'(bus.count_o), ecnt(n));
        chk({tag, "_full"},  BW'(bus.full_o),  efull(f));
    endtask

    initial begin
        n_asrt = 0;
        n_fail = 0;

        // Reset dominates a simultaneous load/shift of all-ones
        RST         = 1'b0;
        bus.clr     = 1'b0;
        bus.load    = 1'b1;
        bus.shift   = 1'b1;
        bus.data_i  = '1;
        bus.block_i = '1;
        tick();
        chk("reset_window", BW'(bus.window_o), '0);
        chk_cnt("reset", 0, 1'b0);

        // Slide fill with 1..16; block_i is X and must not leak in
        RST         = 1'b1;
        bus.load    = 1'b0;
        bus.shift   = 1'b1;
        bus.block_i = 'x;
        for (int k = 1; k <= 16; k++) begin
            bus.data_i = W'(k);
            tick();
            if (k == 1) begin
                chk("first_newest", BW'(bus.newest_o), BW'(32'h0000_0001));
                chk("first_oldest", BW'(bus.oldest_o), '0);
                chk_cnt("first", 1, 1'b0);
            end
            if (k == 15) begin
                chk_cnt("fill15", 15, 1'b0);
            end
        end
        chk("fill_oldest", BW'(bus.oldest_o), BW'(32'h0000_0001));
        chk("fill_newest", BW'(bus.newest_o), BW'(32'h0000_0010));
        for (int i = 0; i < int'(D); i++) exp_win[i*W +: W] = W'(i + 1);
        chk("fill_window", BW'(bus.window_o), BW'(exp_win));
        chk_cnt("fill16", 16, 1'b1);

        // Hold with X on both data inputs
        bus.shift   = 1'b0;
        bus.data_i  = 'x;
        tick();
        chk("hold_window", BW'(bus.window_o), BW'(exp_win));
        chk_cnt("hold", 16, 1'b1);

        // Overflow slide from full
        bus.shift  = 1'b1;
        bus.data_i = 32'hDEAD_BEEF;
        tick();
        chk("ovf_oldest", BW'(bus.oldest_o), BW'(32'h0000_0002));
        chk("ovf_newest", BW'(bus.newest_o), BW'(32'hDEAD_BEEF));
        chk_cnt("ovf", 16, 1'b1);

        // Load beats shift; word i = i*0x11111111
        bus.load   = 1'b1;
        bus.shift  = 1'b1;
        bus.data_i = 32'hCAFE_F00D;
        for (int i = 0; i < int'(D); i++) bus.block_i[i*W +: W] = W'(i * 32'h1111_1111);
        tick();
        chk("load_window", BW'(bus.window_o), BW'(bus.block_i));
        chk("load_newest", BW'(bus.newest_o), BW'(32'hFFFF_FFFF));
        chk("load_oldest", BW'(bus.oldest_o), '0);
        chk_cnt("load", 16, 1'b1);

        // Plain clear empties the window
        bus.clr     = 1'b1;
        bus.load    = 1'b0;
        bus.shift   = 1'b0;
        bus.block_i = 'x;
        tick();
        chk("clr_window", BW'(bus.window_o), '0);
        chk_cnt("clr", 0, 1'b0);

        // Five shifts, then clear beats load mid-stream
        bus.clr   = 1'b0;
        bus.shift = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.data_i = W'(32'h100 + k);
            tick();
        end
        chk("mid_newest", BW'(bus.newest_o), BW'(32'h0000_0104));
        chk_cnt("mid", 5, 1'b0);
        bus.clr     = 1'b1;
        bus.load    = 1'b1;
        bus.block_i = '1;
        tick();
        chk("clrload_window", BW'(bus.window_o), '0);
        chk_cnt("clrload", 0, 1'b0);

        // Shift into an empty window after clear
        bus.clr    = 1'b0;
        bus.load   = 1'b0;
        bus.shift  = 1'b1;
        bus.data_i = 32'hA5A5_A5A5;
        tick();
        chk("a5_newest", BW'(bus.newest_o), BW'(32'hA5A5_A5A5));
        chk("a5_word14", BW'(bus.window_o[14*W +: W]), '0);
        chk_cnt("a5", 1, 1'b0);

        // Reset mid-run with a shift pending, then first edge after release honours load
        RST   = 1'b0;
        tick();
        chk("rst2_window", BW'(bus.window_o), '0);
        chk_cnt("rst2", 0, 1'b0);
        RST         = 1'b1;
        bus.shift   = 1'b0;
        bus.load    = 1'b1;
        for (int i = 0; i < int'(D); i++) bus.block_i[i*W +: W] = W'(32'h5000_0000 + i);
        exp_win = bus.block_i;
        tick();
        chk("release_window", BW'(bus.window_o), BW'(exp_win));
        chk("release_oldest", BW'(bus.oldest_o), BW'(32'h5000_0000));
        chk("release_newest", BW'(bus.newest_o), BW'(32'h5000_000F));
        chk_cnt("release", 16, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
